// File: rtl/sobel_edge_filter.sv
// Sobel edge filter on line-buffer taps: RGB888 -> luma, 3x3 window with
// zero left/right padding, |Gx|+|Gy| magnitude as grey or thresholded binary.
module sobel_edge_filter #(
    parameter int GRAY_R = 77,
    parameter int GRAY_G = 150,
    parameter int GRAY_B = 29
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] img_width,
    input  logic [7:0]  threshold,
    input  logic        edge_mode,
    input  logic [23:0] last_img_data,
    input  logic [23:0] cur_img_data,
    input  logic [23:0] next_img_data,
    input  logic        valid_i,
    output logic [23:0] data_o,
    output logic        valid_o
);

    function automatic logic [7:0] to_luma(input logic [23:0] px);
        return 8'(16'(GRAY_R * int'(px[23:16]) + GRAY_G * int'(px[15:8])
                      + GRAY_B * int'(px[7:0])) >> 8);
    endfunction

    // a + 2b + c, always non-negative and below 1024
    function automatic logic signed [10:0] wsum(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic [7:0] c);
        return 11'(a) + 11'({b, 1'b0}) + 11'(c);
    endfunction

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? 11'(-v) : 11'(v);
    endfunction

    function automatic logic [7:0] sat8(input logic [11:0] m);
        return (m > 12'd255) ? 8'hFF : m[7:0];
    endfunction

    logic [10:0]      col_cnt;
    logic [10:0]      col_p1;
    logic [2:0][7:0]  luma_p1;
    logic             vld_p1;

    logic [2:0][7:0]  l_col, c_col, r_col;
    logic [2:0][7:0]  win_l_p2, win_c_p2, win_r_p2;
    logic             flush_pend;
    logic             vld_p2;

    logic signed [10:0] gx_p3, gy_p3;
    logic               vld_p3;

    logic w_norm;
    assign w_norm = vld_p1 && (col_p1 != 11'd0);

    // S1: luma conversion and column index of the column entering the window
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt <= 11'd0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= valid_i;
            if (valid_i)
                col_cnt <= (col_cnt == img_width - 11'd1) ? 11'd0 : col_cnt + 11'd1;
        end
        col_p1     <= col_cnt;
        luma_p1[0] <= to_luma(last_img_data);
        luma_p1[1] <= to_luma(cur_img_data);
        luma_p1[2] <= to_luma(next_img_data);
    end

    // S2: running window plus a snapshot of each completed window; the snapshot
    // is taken from pre-update registers so a flush and a new line can overlap
    always_ff @(posedge clk) begin
        if (reset) begin
            l_col      <= '0;
            c_col      <= '0;
            r_col      <= '0;
            win_l_p2   <= '0;
            win_c_p2   <= '0;
            win_r_p2   <= '0;
            flush_pend <= 1'b0;
            vld_p2     <= 1'b0;
        end else begin
            vld_p2     <= w_norm || flush_pend;
            flush_pend <= vld_p1 && (col_p1 == img_width - 11'd1);
            if (w_norm)
                {win_l_p2, win_c_p2, win_r_p2} <= {c_col, r_col, luma_p1};
            else if (flush_pend)
                {win_l_p2, win_c_p2, win_r_p2} <= {c_col, r_col, 24'd0};
            if (vld_p1) begin
                l_col <= (col_p1 == 11'd0) ? 24'd0 : c_col;
                c_col <= (col_p1 == 11'd0) ? 24'd0 : r_col;
                r_col <= luma_p1;
            end else if (flush_pend) begin
                l_col <= c_col;
                c_col <= r_col;
                r_col <= '0;
            end
        end
    end

    // S3: Sobel gradients (index 0 = top row, 2 = bottom row)
    always_ff @(posedge clk) begin
        if (reset)
            vld_p3 <= 1'b0;
        else
            vld_p3 <= vld_p2;
        gx_p3 <= wsum(win_r_p2[0], win_r_p2[1], win_r_p2[2])
               - wsum(win_l_p2[0], win_l_p2[1], win_l_p2[2]);
        gy_p3 <= wsum(win_l_p2[2], win_c_p2[2], win_r_p2[2])
               - wsum(win_l_p2[0], win_c_p2[0], win_r_p2[0]);
    end

    logic [7:0] sat_mag;
    assign sat_mag = sat8(12'(abs11(gx_p3)) + 12'(abs11(gy_p3)));

    // S4: magnitude, saturation and output formatting
    always_ff @(posedge clk) begin
        if (reset) begin
            data_o  <= 24'd0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= vld_p3;
            if (vld_p3) begin
                if (edge_mode)
                    data_o <= (sat_mag > threshold) ? 24'hFFFFFF : 24'h000000;
                else
                    data_o <= {3{sat_mag}};
            end
        end
    end

endmodule
